// File: rtl/fifo_stream_reader_if.sv
// Stream side of the FIFO reader: data/valid toward the consumer, ready back.
// master drives m_data/m_valid and samples m_ready; slave is the consumer.
interface fifo_stream_reader_if #(
  parameter int DATA_WIDTH = 16
) ();
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;

  modport master (
    output m_data,
    output m_valid,
    input  m_ready
  );

  modport slave (
    input  m_data,
    input  m_valid,
    output m_ready
  );
endinterface

// File: rtl/fifo_stream_reader.sv
// Reads a 1-cycle-latency FIFO into a 3-deep in-order buffer and streams it out.
// Ports: clk/rst, en, clr_stats, fifo_* side, stream iface m, busy/word_cnt/err.
module fifo_stream_reader #(
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  clr_stats,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  input  logic                  fifo_empty,
  input  logic                  fifo_underflow,
  output logic                  fifo_rd_en,
  fifo_stream_reader_if.master  m,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  word_cnt,
  output logic                  underflow_err
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]            state;
  logic [DATA_WIDTH-1:0] mem [0:2];
  logic [1:0]            occ;
  logic                  inflight;

  logic [2:0] level;
  logic       push;
  logic       drop;
  logic       pop;
  logic [1:0] wr_idx;

  // Credit check counts the word already requested, so the
  // buffer can never be overrun by a read in flight.
  assign level      = {1'b0, occ} + {2'b00, inflight};
  assign fifo_rd_en = (state == RUN) && !fifo_empty && (level < 3'd3);

  assign push = inflight && !fifo_underflow;
  assign drop = inflight && fifo_underflow;

  assign m.m_valid = (occ != 2'd0);
  assign m.m_data  = mem[0];
  assign pop       = m.m_valid && m.m_ready;

  // Tail slot after any shift caused by a same-cycle pop.
  assign wr_idx = pop ? occ - 2'd1 : occ;

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      occ      <= 2'd0;
      inflight <= 1'b0;
      mem[0]   <= '0;
      mem[1]   <= '0;
      mem[2]   <= '0;
    end else begin
      inflight <= fifo_rd_en;

      if (pop) begin
        mem[0] <= mem[1];
        mem[1] <= mem[2];
      end
      // Later assignment wins when the tail lands in a shifted slot.
      if (push) begin
        mem[wr_idx] <= fifo_dout;
      end

      unique case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase

      unique case (state)
        IDLE: begin
          if (en) state <= RUN;
        end
        RUN: begin
          if (!en) begin
            if (occ != 2'd0 || inflight) state <= DRAIN;
            else                          state <= IDLE;
          end
        end
        DRAIN: begin
          if (en)                              state <= RUN;
          else if (occ == 2'd0 && !inflight)   state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr_stats) begin
      word_cnt      <= '0;
      underflow_err <= 1'b0;
    end else begin
      if (pop && word_cnt != {CNT_WIDTH{1'b1}}) begin
        word_cnt <= word_cnt + 1'b1;
      end
      if (drop) begin
        underflow_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader with a behavioural 1-cycle FIFO.
// A second instance with CNT_WIDTH=4 covers counter saturation.
module tb_fifo_stream_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        clr_stats;
  logic [15:0] fifo_dout = '0;
  logic        fifo_empty;
  logic        fifo_underflow = 1'b0;
  logic        fifo_rd_en;
  logic        busy;
  logic [15:0] word_cnt;
  logic        underflow_err;

  fifo_stream_reader_if #(.DATA_WIDTH(16)) sif ();

  fifo_stream_reader #(
    .DATA_WIDTH(16),
    .CNT_WIDTH (16)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .en            (en),
    .clr_stats     (clr_stats),
    .fifo_dout     (fifo_dout),
    .fifo_empty    (fifo_empty),
    .fifo_underflow(fifo_underflow),
    .fifo_rd_en    (fifo_rd_en),
    .m             (sif.master),
    .busy          (busy),
    .word_cnt      (word_cnt),
    .underflow_err (underflow_err)
  );

  logic        s_rst;
  logic        s_en;
  logic        s_clr;
  logic [15:0] s_dout = 16'hABCD;
  logic        s_rd;
  logic        s_busy;
  logic [3:0]  s_cnt;
  logic        s_uerr;

  fifo_stream_reader_if #(.DATA_WIDTH(16)) tif ();

  assign tif.m_ready = 1'b1;

  fifo_stream_reader #(
    .DATA_WIDTH(16),
    .CNT_WIDTH (4)
  ) dut_sat (
    .clk           (clk),
    .rst           (s_rst),
    .en            (s_en),
    .clr_stats     (s_clr),
    .fifo_dout     (s_dout),
    .fifo_empty    (1'b0),
    .fifo_underflow(1'b0),
    .fifo_rd_en    (s_rd),
    .m             (tif.master),
    .busy          (s_busy),
    .word_cnt      (s_cnt),
    .underflow_err (s_uerr)
  );

  always #5 clk = ~clk;

  logic [15:0] fmem [0:63];
  int          rd_ptr = 0;
  int          wr_ptr = 0;
  logic        force_uf;

  assign fifo_empty = (rd_ptr == wr_ptr);

  always @(posedge clk) begin
    if (fifo_rd_en) begin
      fifo_dout      <= fmem[rd_ptr[5:0]];
      fifo_underflow <= force_uf;
      rd_ptr         <= rd_ptr + 1;
    end
  end

  logic [15:0] rx [0:63];
  int          rx_n = 0;
  int          s_xfers = 0;

  always @(posedge clk) begin
    if (sif.m_valid && sif.m_ready) begin
      rx[rx_n[5:0]] <= sif.m_data;
      rx_n          <= rx_n + 1;
    end
    if (tif.m_valid) begin
      s_xfers <= s_xfers + 1;
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [15:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      fmem[wr_ptr[5:0]] = base + 16'(i);
      wr_ptr++;
    end
  endtask

  int rdc;
  int base;

  initial begin
    rst       = 1'b1;
    en        = 1'b1;
    clr_stats = 1'b0;
    force_uf  = 1'b0;
    sif.m_ready = 1'b0;
    s_rst     = 1'b1;
    s_en      = 1'b0;
    s_clr     = 1'b0;

    // reset held with en=1
    repeat (2) begin
      tick();
      chk("rst_rd_en", 32'(fifo_rd_en), 0);
      chk("rst_valid", 32'(sif.m_valid), 0);
      chk("rst_data", 32'(sif.m_data), 0);
      chk("rst_cnt", 32'(word_cnt), 0);
      chk("rst_busy", 32'(busy), 0);
    end
    rst   = 1'b0;
    s_rst = 1'b0;
    en    = 1'b0;
    tick();
    chk("post_rst_busy", 32'(busy), 0);
    chk("post_rst_rd_en", 32'(fifo_rd_en), 0);

    // streaming 1..8
    load(16'h0001, 8);
    sif.m_ready = 1'b1;
    en = 1'b1;
    tick();
    chk("st_first_rd", 32'(fifo_rd_en), 1);
    chk("st_valid_c1", 32'(sif.m_valid), 0);
    tick();
    chk("st_valid_c2", 32'(sif.m_valid), 0);
    tick();
    chk("st_valid_c3", 32'(sif.m_valid), 1);
    chk("st_data_1", 32'(sif.m_data), 1);
    for (int k = 2; k <= 8; k++) begin
      tick();
      chk("st_valid", 32'(sif.m_valid), 1);
      chk("st_data", 32'(sif.m_data), 32'(k));
    end
    tick();
    chk("st_cnt", 32'(word_cnt), 8);
    chk("st_valid_end", 32'(sif.m_valid), 0);
    en = 1'b0;
    tick();
    tick();
    chk("st_idle", 32'(busy), 0);

    // backpressure
    clr_stats   = 1'b1;
    sif.m_ready = 1'b0;
    tick();
    clr_stats = 1'b0;
    load(16'h0001, 8);
    en  = 1'b1;
    rdc = 0;
    repeat (10) begin
      tick();
      if (fifo_rd_en) rdc++;
      if (sif.m_valid) chk("bp_hold", 32'(sif.m_data), 1);
    end
    chk("bp_reads", 32'(rdc), 3);
    chk("bp_occ", 32'(dut.occ), 3);
    chk("bp_valid", 32'(sif.m_valid), 1);
    chk("bp_data", 32'(sif.m_data), 1);
    base = rx_n;
    sif.m_ready = 1'b1;
    for (int i = 0; i < 40 && rx_n < base + 8; i++) tick();
    tick();
    chk("bp_rx_n", 32'(rx_n - base), 8);
    for (int i = 0; i < 8; i++) begin
      chk("bp_order", 32'(rx[base + i]), 32'(i + 1));
    end
    chk("bp_cnt", 32'(word_cnt), 8);
    en = 1'b0;
    for (int i = 0; i < 10 && busy; i++) tick();
    chk("bp_idle", 32'(busy), 0);

    // empty FIFO, then a rejected return
    en  = 1'b1;
    rdc = 0;
    repeat (5) begin
      tick();
      if (fifo_rd_en) rdc++;
    end
    chk("empty_no_rd", 32'(rdc), 0);
    force_uf = 1'b1;
    load(16'h0055, 1);
    repeat (3) tick();
    force_uf = 1'b0;
    chk("uf_err", 32'(underflow_err), 1);
    chk("uf_valid", 32'(sif.m_valid), 0);
    chk("uf_occ", 32'(dut.occ), 0);
    chk("uf_cnt", 32'(word_cnt), 8);
    repeat (2) tick();
    chk("uf_sticky", 32'(underflow_err), 1);
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
    chk("uf_clr_err", 32'(underflow_err), 0);
    chk("uf_clr_cnt", 32'(word_cnt), 0);
    en = 1'b0;
    tick();
    tick();
    chk("uf_idle", 32'(busy), 0);

    // drain with one read in flight and two buffered
    sif.m_ready = 1'b0;
    load(16'h0021, 3);
    en = 1'b1;
    repeat (4) tick();
    chk("dr_occ2", 32'(dut.occ), 2);
    chk("dr_inflight", 32'(dut.inflight), 1);
    en = 1'b0;
    tick();
    chk("dr_state", 32'(dut.state), 2);
    chk("dr_busy", 32'(busy), 1);
    base = rx_n;
    sif.m_ready = 1'b1;
    for (int i = 0; i < 20 && busy; i++) tick();
    chk("dr_idle", 32'(busy), 0);
    chk("dr_rx_n", 32'(rx_n - base), 3);
    for (int i = 0; i < 3; i++) begin
      chk("dr_order", 32'(rx[base + i]), 32'h21 + 32'(i));
    end
    chk("dr_occ0", 32'(dut.occ), 0);

    // 4-bit counter saturation
    s_en = 1'b1;
    for (int i = 0; i < 100 && s_xfers < 20; i++) tick();
    chk("sat_xfers", 32'(s_xfers >= 20), 1);
    chk("sat_cnt_run", 32'(s_cnt), 15);
    s_en = 1'b0;
    for (int i = 0; i < 20 && s_busy; i++) tick();
    chk("sat_idle", 32'(s_busy), 0);
    chk("sat_cnt", 32'(s_cnt), 15);
    s_en = 1'b1;
    for (int i = 0; i < 10 && !tif.m_valid; i++) tick();
    chk("sat_valid", 32'(tif.m_valid), 1);
    s_clr = 1'b1;
    tick();
    s_clr = 1'b0;
    s_en  = 1'b0;
    chk("sat_clr_pri", 32'(s_cnt), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_stream_reader.md
FIFO_STREAM_READER -- requirements
Module: fifo_stream_reader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, the FIFO word and stream data width.
REQ-002 SHALL have parameter CNT_WIDTH, default 16, the width of the delivered-word counter.
REQ-003 SHALL have one clock and a synchronous, active-high reset.
REQ-004 Port clk, input, 1, rising-edge clock shared with the upstream FIFO.
REQ-005 Port rst, input, 1, synchronous active-high reset.
REQ-006 Port en, input, 1, enables issuing new FIFO reads.
REQ-007 Port clr_stats, input, 1, synchronous clear of word_cnt and underflow_err.
REQ-008 Port fifo_dout, input, DATA_WIDTH, FIFO read data, valid the cycle after fifo_rd_en.
REQ-009 Port fifo_empty, input, 1, FIFO empty flag.
REQ-010 Port fifo_underflow, input, 1, FIFO underflow flag, qualifies the returned word.
REQ-011 Port fifo_rd_en, output, 1, FIFO read strobe.
REQ-012 Port m_data, output, DATA_WIDTH, stream data; the head of the output buffer.
REQ-013 Port m_valid, output, 1, stream valid.
REQ-014 Port m_ready, input, 1, stream ready from the consumer.
REQ-015 Port busy, output, 1, high when state is not IDLE.
REQ-016 Port word_cnt, output, CNT_WIDTH, count of completed stream transfers.
REQ-017 Port underflow_err, output, 1, sticky flag set by a rejected read return.

Function
REQ-018 SHALL hold a 3-entry in-order output buffer, with occupancy occ in the range 0..3, and a 1-bit register inflight that equals the previous cycle's fifo_rd_en.
REQ-019 SHALL drive fifo_rd_en = (state==RUN) && !fifo_empty && (occ + inflight) < 3, using only registered occ and inflight, with no m_ready term.
REQ-020 SHALL, in any cycle with inflight=1 and fifo_underflow=0, write fifo_dout to the buffer tail; occ increments at that clock edge unless a pop occurs in the same cycle.
REQ-021 SHALL, in any cycle with inflight=1 and fifo_underflow=1, discard the word, leave occ unchanged and set underflow_err.
REQ-022 SHALL drive m_valid = (occ != 0) and m_data = the buffer head, with no bypass: a returned word first appears on m_data one cycle after it is on fifo_dout.
REQ-023 SHALL pop the head on m_valid && m_ready; a simultaneous push and pop keeps occ unchanged and preserves order.
REQ-024 SHALL hold m_data stable while m_valid=1 and m_ready=0.
REQ-025 SHALL never overflow the buffer: occ + inflight is never greater than 3.
REQ-026 SHALL sustain one transfer per cycle in steady state when m_ready=1 and the FIFO is non-empty.
REQ-027 SHALL increment word_cnt on each transfer, saturating at 2^CNT_WIDTH-1.
REQ-028 SHALL give clr_stats priority over an increment or error in the same cycle, so the result is 0.
REQ-029 SHALL implement the state machine as follows:
  - IDLE: transitions to RUN when en=1.
  - RUN: when en=0, transitions to DRAIN if occ != 0 or inflight=1, otherwise to IDLE.
  - DRAIN: issues no reads; transitions to RUN when en=1; otherwise transitions to IDLE once occ == 0 and inflight=0.
REQ-030 SHALL, in IDLE, keep fifo_rd_en=0 while still presenting any buffered words on the stream.

Reset
REQ-031 SHALL, on rst=1 at a clock edge, clear the following: state to IDLE, occ=0, inflight=0, m_valid=0, m_data=0, word_cnt=0, underflow_err=0; fifo_rd_en is then 0.
REQ-032 SHALL, on reset mid-operation, drop all buffered data and ignore any FIFO return in the cycle after reset, with no push and no error flag.

Verification
REQ-033 Reset: assert rst for 2 cycles with en=1 -> fifo_rd_en=0, m_valid=0, word_cnt=0 and busy=0 during and one cycle after.
REQ-034 Streaming: FIFO preloaded with 8 words 0x0001..0x0008, en=1, m_ready=1 -> first fifo_rd_en in cycle 1 after en, first m_valid 2 cycles later, words 1..8 on consecutive cycles, word_cnt=8.
REQ-035 Backpressure: m_ready=0 with 8 words available -> exactly 3 reads issued, occ=3, m_data=0x0001 held; release m_ready -> remaining words in order, no loss or duplication.
REQ-036 Empty and underflow: fifo_empty=1 -> no fifo_rd_en; forcing fifo_underflow=1 on a return cycle -> word dropped, underflow_err=1 until clr_stats, word_cnt unchanged.
REQ-037 Drain: deassert en while 1 read is in flight and 2 words are buffered -> state DRAIN, all 3 words delivered, then IDLE and busy=0.
REQ-038 Saturation: CNT_WIDTH=4 with 20 transfers -> word_cnt stops at 15; a simultaneous clr_stats and transfer -> word_cnt=0.
